// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store controller: op codes, FSM states
// and the lane extract/extend and lane merge helpers.
package lsu_pkg;

    localparam logic [3:0] OP_LB  = 4'b0000;
    localparam logic [3:0] OP_LH  = 4'b0001;
    localparam logic [3:0] OP_LW  = 4'b0010;
    localparam logic [3:0] OP_LBU = 4'b0100;
    localparam logic [3:0] OP_LHU = 4'b0101;
    localparam logic [3:0] OP_SB  = 4'b1000;
    localparam logic [3:0] OP_SH  = 4'b1001;
    localparam logic [3:0] OP_SW  = 4'b1010;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WR,
        S_RESP
    } state_t;

    function automatic logic op_legal(input logic [3:0] op);
        logic ok;
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: ok = 1'b1;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // op[2] selects zero-extension, op[1:0] the access size.
    function automatic logic [31:0] lane_extract(input logic [2:0]  op,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (op[1:0])
            SZ_BYTE: r = op[2] ? {24'h0, b} : {{24{b[7]}}, b};
            SZ_HALF: r = op[2] ? {16'h0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Replace the addressed lane of the old word with the low store bits.
    function automatic logic [31:0] lane_merge(input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic [31:0] word,
                                               input logic [31:0] wdata);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_BYTE: r[{lane, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (lane[1]) r[31:16] = wdata[15:0];
                else         r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: load extract/extend and sub-word store merge,
// both keyed by the size/sign field of the op and the byte lane.
import lsu_pkg::*;

module lsu_lane_align (
    input  logic [2:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    // Both views of the captured RAM word; the FSM picks which one it keeps.
    always_comb begin
        load_data  = lane_extract(op, lane, rdata);
        merge_data = lane_merge(op[1:0], lane, rdata, wdata);
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller between the CPU memory stage and a word-wide data RAM.
// Sub-word stores use read-modify-write. Build option LSU_MISALIGN_TRAP_EN turns
// misaligned halfword/word accesses into error responses; without it the low
// address bits are forced to the access alignment.
import lsu_pkg::*;

module lsu_ctrl #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              ram_ena,
    output logic              ram_wena,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    state_t            state, state_next;
    logic [3:0]        op_q;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merged_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic              req_err;
    logic [ADDR_W+1:0] addr_eff;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;

    assign accept     = req_valid && (state == S_IDLE);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    // Classify the incoming request and derive the address actually used.
    always_comb begin
        req_err  = !op_legal(req_op);
        addr_eff = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
        if ((req_op[1:0] == SZ_HALF) && req_addr[0])
            req_err = 1'b1;
        if ((req_op[1:0] == SZ_WORD) && (req_addr[1:0] != 2'b00))
            req_err = 1'b1;
`else
        if (req_op[1:0] == SZ_HALF)
            addr_eff[0] = 1'b0;
        else if (req_op[1:0] == SZ_WORD)
            addr_eff[1:0] = 2'b00;
`endif
    end

    lsu_lane_align u_align (
        .op         (op_q[2:0]),
        .lane       (addr_q[1:0]),
        .rdata      (ram_rdata),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .merge_data (merge_data)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next state and all handshake/RAM outputs, decoded from the registered state.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        ram_ena    = 1'b0;
        ram_wena   = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (accept) begin
                    if (req_err)              state_next = S_RESP;
                    else if (req_op == OP_SW) state_next = S_WR;
                    else                      state_next = S_RD;
                end
            end
            S_RD: begin
                ram_ena    = 1'b1;
                ram_addr   = addr_q[ADDR_W+1:2];
                state_next = S_CAP;
            end
            S_CAP: begin
                state_next = op_q[3] ? S_WR : S_RESP;
            end
            S_WR: begin
                ram_ena    = 1'b1;
                ram_wena   = 1'b1;
                ram_addr   = addr_q[ADDR_W+1:2];
                ram_wdata  = (op_q == OP_SW) ? wdata_q : merged_q;
                state_next = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
        // A reset landing in RD/WR must not reach the RAM in that same cycle.
        if (rst) begin
            ram_ena   = 1'b0;
            ram_wena  = 1'b0;
            ram_addr  = '0;
            ram_wdata = '0;
        end
    end

    // Request latch on acceptance and merged word capture for sub-word stores.
    always_ff @(posedge clk) begin
        if (accept) begin
            op_q    <= req_op;
            addr_q  <= addr_eff;
            wdata_q <= req_wdata;
        end
        if (state == S_CAP)
            merged_q <= merge_data;
    end

    // Response payload: cleared on acceptance, filled in CAP for loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            rdata_q <= '0;
            err_q   <= req_err;
        end else if ((state == S_CAP) && !op_q[3]) begin
            rdata_q <= load_data;
        end
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store controller between the CPU memory stage and the 32-word data RAM. Accepts one byte/halfword/word load or store per request over a valid/ready handshake. Drives the RAM's word-wide port, performs read-modify-write for sub-word stores, and returns sign/zero-extended load data with a registered response handshake.

## Interface
Parameters:
- ADDR_W, 5, RAM word-address width; byte address is ADDR_W+2 bits.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_op  in  4  operation code; bit 3 = store, bits 2:0 = size/sign
- req_addr  in  ADDR_W+2  byte address, little-endian
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes the response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal op, or misaligned access when trapping is enabled
- ram_ena  out  1  RAM enable
- ram_wena  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM word address
- ram_wdata  out  32  RAM write data
- ram_rdata  in  32  RAM read data, valid the cycle after a read cycle (ram_ena=1, ram_wena=0)

## Operation
- Op codes:
  - Loads: 0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU.
  - Stores: 1000 SB, 1001 SH, 1010 SW.
  - Any other code is illegal: no RAM access, response with resp_err=1.
- FSM states: IDLE, RD, CAP, WR, RESP. req_ready=1 only in IDLE.
- A request is accepted on an edge with req_valid & req_ready. Op, address and data are latched on acceptance.
- Transitions after acceptance:
  - Load: IDLE→RD→CAP→RESP.
  - SW: IDLE→WR→RESP.
  - SB/SH: IDLE→RD→CAP→WR→RESP.
  - Illegal or trapped: IDLE→RESP.
- RD: ram_ena=1, ram_wena=0, ram_addr=latched byte address[ADDR_W+1:2].
- CAP: samples ram_rdata.
  - Loads: select byte/half by addr[1:0] (byte n = bits 8n+7:8n), then sign-extend (LB/LH) or zero-extend (LBU/LHU).
  - Sub-word stores: merge wdata[7:0] or wdata[15:0] into the read word at the addressed lane.
- WR: ram_ena=1, ram_wena=1, ram_wdata=merged word, or req_wdata for SW.
- RESP: resp_valid=1 and held, with stable resp_rdata/resp_err, until resp_ready. Exit to IDLE on the edge where resp_ready=1.
- ram_ena=0 in IDLE, CAP and RESP. ram_wena=0 outside WR.
- Halfword uses addr[1]; addr[0] is ignored unless trapping is enabled.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, ram_ena=0, ram_wena=0, ram_addr=0, ram_wdata=0.
- Latency from acceptance edge N to first resp_valid cycle:
  - Load: N+3.
  - SW: N+2.
  - SB/SH: N+4.
  - Illegal/trapped: N+1.
- Throughput: one request per (latency+1) cycles when resp_ready is held high.
- RAM outputs are decoded from the registered state and gated by !rst. Reset asserted during WR produces no write that cycle.
- Reset mid-operation aborts the request with no response. Any RD already issued is harmless; a WR not yet reached is never issued.
- resp_ready is ignored outside RESP. req_valid is ignored outside IDLE, so requests are never dropped silently; the requester holds them.
- Address wrap: the top byte address 0x7F maps to word 31; there is no wrap beyond the RAM.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Halfword with addr[0]=1, or word with addr[1:0]≠0, responds with resp_err=1 and performs no RAM access.
- Undefined:
  - Low address bits below the access size are forced to 0, so the access proceeds aligned and resp_err is only raised for illegal ops.

## Structure
- Shared package lsu_pkg:
  - op code localparams.
  - State enum.
  - Helpers: lane extract/extend and lane merge.
- One sub-module, lsu_lane_align: combinational extract+extend for loads and merge for stores, keyed by op and addr[1:0]. The FSM stays in lsu_ctrl.

## Test plan
- SW addr 0x08 data 0xDEADBEEF, then LW 0x08 → RAM word 2 = 0xDEADBEEF; resp_rdata=0xDEADBEEF at N+3; ram_ena never asserted in CAP.
- With word 0 = 0x11223344, SB addr 0x02 data 0xA5 → word 0 = 0x11A53344. Then LB 0x02 → 0xFFFFFFA5, LBU 0x02 → 0x000000A5.
- SH addr 0x06 data 0x8001 on word 1 = 0 → word 1 = 0x80010000. Then LH 0x06 → 0xFFFF8001, LHU 0x06 → 0x00008001.
- Op 0111 → resp_err=1, resp_rdata=0, no RAM activity. LW 0x05:
  - with LSU_MISALIGN_TRAP_EN: resp_err=1.
  - without: reads word 1.
- Hold resp_ready=0 for 5 cycles in RESP → resp_valid and data stable, req_ready=0; a new request is accepted only after the resp_ready edge.
- Assert rst during WR of an SB → no write; word unchanged; all outputs at reset values next cycle; req_ready=1.
